// File: rtl/parametric_cache_bank.sv
// Cache-bank front end: round-robin (optionally critical-first) arbitration into a miss queue,
// plus a buffered return queue. Optional macro: CACHE_BANK_CRITICAL_EN enables critical-first arbitration.

module cache_bank_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_req,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop_ack,
    output logic                       full,
    output logic                       valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic             push, pop;

    // Explicit wrap compare so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign valid     = (count != '0);
    assign push      = push_req & ~full;
    assign pop       = valid & pop_ack;
    assign head_data = valid ? mem[head] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage is intentionally not reset; only the pointers define occupancy.
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= push_data;
    end
endmodule

module parametric_cache_bank #(
    parameter int NUM_PORTS  = 2,
    parameter int REQ_WIDTH  = 80,
    parameter int MISS_DEPTH = 4,
    parameter int RET_DEPTH  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS*REQ_WIDTH-1:0]  io_input_request_flatted_in,
    input  logic [NUM_PORTS-1:0]            io_input_request_valid_flatted_in,
    input  logic [NUM_PORTS-1:0]            io_input_request_critical_flatted_in,
    output logic [NUM_PORTS-1:0]            io_input_request_ack_out,
    input  logic [REQ_WIDTH-1:0]            io_fetched_request_in,
    input  logic                            io_fetched_request_valid_in,
    output logic                            io_fetch_ack_out,
    output logic [REQ_WIDTH-1:0]            io_miss_request_out,
    output logic                            io_miss_request_valid_out,
    input  logic                            io_miss_request_ack_in,
    output logic [REQ_WIDTH-1:0]            io_return_request_out,
    output logic                            io_return_request_valid_out,
    input  logic                            io_return_request_ack_in,
    output logic [$clog2(MISS_DEPTH+1)-1:0] io_miss_queue_count_out
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] cand;
    logic [PORT_W-1:0]    rr_ptr, win_idx;
    logic                 win_found, accept, miss_full, ret_full, fetch_push;
    logic [REQ_WIDTH-1:0] win_data;

`ifdef CACHE_BANK_CRITICAL_EN
    logic [NUM_PORTS-1:0] crit_valid;
    assign crit_valid = io_input_request_valid_flatted_in & io_input_request_critical_flatted_in;
    assign cand       = (crit_valid != '0) ? crit_valid : io_input_request_valid_flatted_in;
`else
    logic [NUM_PORTS-1:0] unused_critical;
    assign unused_critical = io_input_request_critical_flatted_in;
    assign cand            = io_input_request_valid_flatted_in;
`endif

    // Scan candidates starting at rr_ptr; first hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!win_found && cand[(int'(rr_ptr) + i) % NUM_PORTS]) begin
                win_found = 1'b1;
                win_idx   = PORT_W'((int'(rr_ptr) + i) % NUM_PORTS);
            end
        end
    end

    always_comb begin
        win_data = io_input_request_flatted_in[int'(win_idx)*REQ_WIDTH +: REQ_WIDTH];
    end

    // Reset gating keeps every output at 0 while reset is held, even with live inputs.
    assign accept                   = win_found & ~miss_full & ~reset;
    assign io_input_request_ack_out = accept ? (NUM_PORTS'(1) << win_idx) : '0;
    assign fetch_push               = io_fetched_request_valid_in & ~ret_full & ~reset;
    assign io_fetch_ack_out         = fetch_push;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (win_idx == PORT_W'(NUM_PORTS-1)) ? '0 : win_idx + 1'b1;
        end
    end

    cache_bank_queue #(.DEPTH(MISS_DEPTH), .WIDTH(REQ_WIDTH)) u_miss_q (
        .clock     (clock),
        .reset     (reset),
        .push_req  (accept),
        .push_data (win_data),
        .pop_ack   (io_miss_request_ack_in),
        .full      (miss_full),
        .valid     (io_miss_request_valid_out),
        .head_data (io_miss_request_out),
        .count     (io_miss_queue_count_out)
    );

    logic [$clog2(RET_DEPTH+1)-1:0] unused_ret_count;

    cache_bank_queue #(.DEPTH(RET_DEPTH), .WIDTH(REQ_WIDTH)) u_ret_q (
        .clock     (clock),
        .reset     (reset),
        .push_req  (fetch_push),
        .push_data (io_fetched_request_in),
        .pop_ack   (io_return_request_ack_in),
        .full      (ret_full),
        .valid     (io_return_request_valid_out),
        .head_data (io_return_request_out),
        .count     (unused_ret_count)
    );
endmodule

// File: tb/tb_parametric_cache_bank.sv
// Self-checking bench for parametric_cache_bank: arbitration table, queue-full, return path,
// async reset and pointer wrap (second instance with MISS_DEPTH=3).

module tb_parametric_cache_bank;
    logic         clock = 1'b0;
    logic         reset;
    logic [159:0] req_flat;
    logic [1:0]   req_valid, req_crit;
    logic [1:0]   ack, ack3;
    logic [79:0]  fetch_data;
    logic         fetch_valid, fetch_ack;
    logic [79:0]  miss_data, miss3_data;
    logic         miss_valid, miss3_valid, miss_ack;
    logic [79:0]  ret_data;
    logic         ret_valid, ret_ack;
    logic [2:0]   miss_count;
    logic [1:0]   count3;
    logic         unused_fetch_ack3, unused_ret3_valid;
    logic [79:0]  unused_ret3_data;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk3      = 1'b0;

    logic [79:0] miss_q[$];
    logic [79:0] ret_q[$];
    logic [79:0] q3[$];

    typedef struct {
        logic [1:0] valid;
        logic [1:0] crit;
        logic [1:0] exp_ack;
    } arb_vec_t;
    arb_vec_t tbl [11];

    always #5 clock = ~clock;

    parametric_cache_bank dut (
        .clock                                (clock),
        .reset                                (reset),
        .io_input_request_flatted_in          (req_flat),
        .io_input_request_valid_flatted_in    (req_valid),
        .io_input_request_critical_flatted_in (req_crit),
        .io_input_request_ack_out             (ack),
        .io_fetched_request_in                (fetch_data),
        .io_fetched_request_valid_in          (fetch_valid),
        .io_fetch_ack_out                     (fetch_ack),
        .io_miss_request_out                  (miss_data),
        .io_miss_request_valid_out            (miss_valid),
        .io_miss_request_ack_in               (miss_ack),
        .io_return_request_out                (ret_data),
        .io_return_request_valid_out          (ret_valid),
        .io_return_request_ack_in             (ret_ack),
        .io_miss_queue_count_out              (miss_count)
    );

    parametric_cache_bank #(.MISS_DEPTH(3)) dut3 (
        .clock                                (clock),
        .reset                                (reset),
        .io_input_request_flatted_in          (req_flat),
        .io_input_request_valid_flatted_in    (req_valid),
        .io_input_request_critical_flatted_in (req_crit),
        .io_input_request_ack_out             (ack3),
        .io_fetched_request_in                (fetch_data),
        .io_fetched_request_valid_in          (fetch_valid),
        .io_fetch_ack_out                     (unused_fetch_ack3),
        .io_miss_request_out                  (miss3_data),
        .io_miss_request_valid_out            (miss3_valid),
        .io_miss_request_ack_in               (miss_ack),
        .io_return_request_out                (unused_ret3_data),
        .io_return_request_valid_out          (unused_ret3_valid),
        .io_return_request_ack_in             (ret_ack),
        .io_miss_queue_count_out              (count3)
    );

    function automatic logic [79:0] pdata(input int p, input int n);
        return {16'hCAFE, 48'h0, 8'(p), 8'(n)};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare queue heads whenever the DUT pops them.
    always @(negedge clock) begin
        if (!reset) begin
            if (miss_valid && miss_ack) begin
                check("miss_q_nonempty", 80'(miss_q.size() != 0), 80'd1);
                if (miss_q.size() != 0) check("miss_data", miss_data, miss_q.pop_front());
            end
            if (ret_valid && ret_ack) begin
                check("ret_q_nonempty", 80'(ret_q.size() != 0), 80'd1);
                if (ret_q.size() != 0) check("ret_data", ret_data, ret_q.pop_front());
            end
            if (chk3 && miss3_valid && miss_ack) begin
                check("wrap_q_nonempty", 80'(q3.size() != 0), 80'd1);
                if (q3.size() != 0) check("wrap_data", miss3_data, q3.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{2'b11, 2'b00, 2'b01};
        tbl[1]  = '{2'b11, 2'b00, 2'b10};
        tbl[2]  = '{2'b11, 2'b00, 2'b01};
        tbl[3]  = '{2'b11, 2'b00, 2'b10};
        tbl[4]  = '{2'b01, 2'b00, 2'b01};
        tbl[5]  = '{2'b01, 2'b00, 2'b01};
        tbl[6]  = '{2'b10, 2'b00, 2'b10};
        tbl[7]  = '{2'b00, 2'b00, 2'b00};
`ifdef CACHE_BANK_CRITICAL_EN
        tbl[8]  = '{2'b11, 2'b10, 2'b10};
        tbl[9]  = '{2'b11, 2'b01, 2'b01};
        tbl[10] = '{2'b11, 2'b11, 2'b10};
`else
        tbl[8]  = '{2'b11, 2'b10, 2'b01};
        tbl[9]  = '{2'b11, 2'b01, 2'b10};
        tbl[10] = '{2'b11, 2'b11, 2'b01};
`endif

        reset       = 1'b1;
        req_flat    = '0;
        req_valid   = '0;
        req_crit    = '0;
        fetch_data  = '0;
        fetch_valid = 1'b0;
        miss_ack    = 1'b0;
        ret_ack     = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset / idle
        @(negedge clock);
        check("idle_ack", 80'(ack), 80'd0);
        check("idle_fetch_ack", 80'(fetch_ack), 80'd0);
        check("idle_miss_valid", 80'(miss_valid), 80'd0);
        check("idle_miss_data", miss_data, 80'd0);
        check("idle_ret_valid", 80'(ret_valid), 80'd0);
        check("idle_ret_data", ret_data, 80'd0);
        check("idle_count", 80'(miss_count), 80'd0);
        tick();

        // Arbitration table with the miss queue draining every cycle
        miss_ack = 1'b1;
        for (int i = 0; i < 11; i++) begin
            req_valid = tbl[i].valid;
            req_crit  = tbl[i].crit;
            req_flat  = {pdata(1, i), pdata(0, i)};
            @(negedge clock);
            check($sformatf("arb_ack[%0d]", i), 80'(ack), 80'(tbl[i].exp_ack));
            if (i == 0) check("miss_no_bypass", 80'(miss_valid), 80'd0);
            if (tbl[i].exp_ack[0])      miss_q.push_back(pdata(0, i));
            else if (tbl[i].exp_ack[1]) miss_q.push_back(pdata(1, i));
            tick();
        end
        req_valid = '0;
        req_crit  = '0;
        repeat (3) tick();
        @(negedge clock);
        check("arb_drained", 80'(miss_valid), 80'd0);
        tick();

        // Miss queue fill to full, then pop with a blocked request pending
        miss_ack  = 1'b0;
        req_valid = 2'b01;
        for (int n = 1; n <= 4; n++) begin
            req_flat = {80'd0, 80'(n)};
            @(negedge clock);
            check($sformatf("fill_ack[%0d]", n), 80'(ack), 80'd1);
            miss_q.push_back(80'(n));
            tick();
        end
        req_flat = {80'd0, 80'd5};
        @(negedge clock);
        check("full_count", 80'(miss_count), 80'd4);
        check("full_ack", 80'(ack), 80'd0);
        check("full_head", miss_data, 80'd1);
        tick();
        miss_ack = 1'b1;
        @(negedge clock);
        check("full_pop_same_cycle_ack", 80'(ack), 80'd0);
        tick();
        @(negedge clock);
        check("after_pop_count", 80'(miss_count), 80'd3);
        check("after_pop_ack", 80'(ack), 80'd1);
        miss_q.push_back(80'd5);
        tick();
        req_valid = '0;
        repeat (4) tick();
        @(negedge clock);
        check("drain_count", 80'(miss_count), 80'd0);
        tick();

        // Return path fill and drain
        for (int n = 1; n <= 5; n++) begin
            fetch_data  = 80'h5200 + 80'(n);
            fetch_valid = 1'b1;
            @(negedge clock);
            check($sformatf("fetch_ack[%0d]", n), 80'(fetch_ack), 80'(n <= 4));
            if (n <= 4) ret_q.push_back(80'h5200 + 80'(n));
            tick();
        end
        fetch_valid = 1'b0;
        @(negedge clock);
        check("ret_head", ret_data, 80'h5201);
        tick();
        ret_ack = 1'b1;
        repeat (5) tick();
        @(negedge clock);
        check("ret_drained", 80'(ret_valid), 80'd0);
        tick();

        // Async reset with entries in flight
        miss_ack  = 1'b0;
        ret_ack   = 1'b0;
        req_valid = 2'b01;
        for (int n = 0; n < 3; n++) begin
            req_flat    = {80'd0, pdata(0, 40 + n)};
            fetch_data  = 80'h7700 + 80'(n);
            fetch_valid = 1'b1;
            @(negedge clock);
            check($sformatf("pre_rst_ack[%0d]", n), 80'(ack), 80'd1);
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        check("rst_miss_valid", 80'(miss_valid), 80'd0);
        check("rst_ret_valid", 80'(ret_valid), 80'd0);
        check("rst_count", 80'(miss_count), 80'd0);
        check("rst_ack", 80'(ack), 80'd0);
        check("rst_fetch_ack", 80'(fetch_ack), 80'd0);
        miss_q.delete();
        ret_q.delete();
        tick();
        req_valid   = '0;
        fetch_valid = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_miss_valid", 80'(miss_valid), 80'd0);
        check("post_rst_ret_valid", 80'(ret_valid), 80'd0);
        tick();
        req_valid = 2'b11;
        req_flat  = {pdata(1, 50), pdata(0, 50)};
        @(negedge clock);
        check("post_rst_rr_ptr", 80'(ack), 80'd1);
        miss_q.push_back(pdata(0, 50));
        tick();
        req_valid = '0;
        miss_ack  = 1'b1;
        repeat (2) tick();

        // Pointer wrap on the MISS_DEPTH=3 instance
        chk3      = 1'b1;
        miss_ack  = 1'b0;
        req_valid = 2'b01;
        for (int n = 0; n < 12; n++) begin
            if (n == 2) miss_ack = 1'b1;
            req_flat = {80'd0, pdata(0, 100 + n)};
            @(negedge clock);
            check($sformatf("wrap_ack[%0d]", n), 80'(ack3), 80'd1);
            if (n >= 2) check($sformatf("wrap_count[%0d]", n), 80'(count3), 80'd2);
            miss_q.push_back(pdata(0, 100 + n));
            q3.push_back(pdata(0, 100 + n));
            tick();
        end
        req_valid = '0;
        repeat (4) tick();
        @(negedge clock);
        check("wrap_drained_valid", 80'(miss3_valid), 80'd0);
        check("wrap_drained_count", 80'(count3), 80'd0);
        check("miss_sb_empty", 80'(miss_q.size()), 80'd0);
        check("ret_sb_empty", 80'(ret_q.size()), 80'd0);
        check("wrap_sb_empty", 80'(q3.size()), 80'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
